mult_ctrl: RTL
==============

# mult_ctrl

Control FSM that sequences the 8-bit signed add-shift multiplier datapath (X:A:B shift-register chain, 9-bit adder/subtractor). It clears the accumulator on start, then for each of 8 multiplier bits optionally loads the adder result into X:A, based on the current B LSB (`M`), and arithmetic-shifts the chain. The final bit is subtracted (two's-complement sign weight). It sits between the switch/button front end and the register unit plus adder, and owns every load, clear and shift strobe.

## Interface
Parameters:
- `NUM_BITS`, default 8: multiplier width, i.e. the iteration count. Must be a power of two, at most 16.

Ports:
- `Clk` in 1: system clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Run` in 1: start request, level. Already synchronized/debounced upstream.
- `ClearA_LoadB` in 1: load switches into B and clear X:A. Honored only in IDLE.
- `M` in 1: current B[0] from the register unit.
- `Clr_XA` out 1: synchronous clear of X and A this cycle.
- `Ld_B` out 1: load B from switches this cycle.
- `Ld_XA` out 1: load adder result into X:A this cycle.
- `Fn` out 1: adder function, 0 = A+S, 1 = A−S. Valid whenever `Ld_XA`=1.
- `Shift_En` out 1: arithmetic right shift of X:A:B this cycle.
- `Busy` out 1: high in CLR, ADD, SHIFT.
- `Done` out 1: one-cycle pulse on entry to HOLD.

## Operation
States: IDLE, CLR, ADD, SHIFT, HOLD. Iteration counter `cnt` is log2(NUM_BITS) bits.

- IDLE:
  - `ClearA_LoadB`=1: `Ld_B`=1 and `Clr_XA`=1 in the same cycle; stay in IDLE.
  - Otherwise, `Run`=1 → CLR.
  - `ClearA_LoadB` has priority over `Run`. A held `Run` starts on the first cycle `ClearA_LoadB`=0.
- CLR: `Clr_XA`=1. `cnt` ← 0. → ADD.
- ADD:
  - `M`=1: `Ld_XA`=1, with `Fn`=1 if `cnt`==NUM_BITS−1, else `Fn`=0.
  - `M`=0: no strobes.
  - → SHIFT.
- SHIFT: `Shift_En`=1.
  - `cnt`==NUM_BITS−1 → HOLD.
  - Otherwise `cnt` ← `cnt`+1, → ADD.
- HOLD:
  - `Done`=1 on the entry cycle only.
  - Stay while `Run`=1. `Run`=0 → IDLE.
  - Ignores `ClearA_LoadB`.
- Strobe decode is combinational from state, `cnt` and `M`. The state register and `cnt` are the only flops, plus a `Done` edge flag if needed.
- At most one of `Ld_XA`, `Shift_En`, `Clr_XA` is high in any cycle, except IDLE, where `Clr_XA` and `Ld_B` coincide.
- `M` is sampled only in ADD. The datapath must present the post-shift B[0].

## Timing
- Reset (async assert, sync deassert handled upstream):
  - state = IDLE, `cnt` = 0.
  - All outputs 0: `Clr_XA`, `Ld_B`, `Ld_XA`, `Fn`, `Shift_En`, `Busy`, `Done`.
- Reset mid-operation returns to IDLE immediately. Datapath contents are not cleared by this block.
- Start latency: `Run` high in IDLE at edge k gives CLR in cycle k+1.
- Multiply, without the macro: 1 (CLR) + 2·NUM_BITS cycles. That is 17 for NUM_BITS=8, with `Done` in cycle k+18.
- `Run` held high through completion does not retrigger. A new multiply needs `Run` low for ≥1 cycle in HOLD/IDLE.
- `Fn` defaults to 0 when `Ld_XA`=0.

## Configuration
- `MULT_CTRL_SKIP_ADD_EN` defined:
  - ADD is skipped when `M`=0. SHIFT goes directly to SHIFT for the next bit, and CLR goes to SHIFT if `M`=0.
  - Latency = 1 + NUM_BITS + popcount(B).
  - `Done` is still exactly one pulse.
- Undefined: fixed-latency behaviour above, with every bit spending one ADD and one SHIFT cycle.

## Structure
- Package `mult_pkg`:
  - `mult_state_e` enum (IDLE, CLR, ADD, SHIFT, HOLD).
  - `MULT_BITS` = 8 default.
  - `FN_ADD`/`FN_SUB` constants.
- One sub-module, `mult_bit_cnt`: iteration counter with clear, increment and a `last` flag (`cnt`==NUM_BITS−1). The FSM stays in `mult_ctrl`.

## Test plan
- Reset with `Reset_n`=0 asserted mid-SHIFT (`cnt`=3) → all outputs 0 the same cycle; IDLE after release; `Busy`=0.
- `ClearA_LoadB`=1 and `Run`=1 together in IDLE → `Ld_B`=1 and `Clr_XA`=1, no CLR. Dropping `ClearA_LoadB` → CLR next cycle.
- B=0x05 (bench models the shift chain, so the `M` sequence is 1,0,1,0,0,0,0,0) → `Ld_XA` in ADD cycles of iterations 0 and 2 with `Fn`=0; 8 `Shift_En` pulses; `Done` 17 cycles after CLR entry.
- B=0x80 → `Ld_XA`=1 only in iteration 7, with `Fn`=1.
- `Run` held 40 cycles → single `Done` pulse, stays in HOLD. `Run` low 1 cycle then high → new CLR.
- With `MULT_CTRL_SKIP_ADD_EN` and B=0x05 → 2 ADD cycles, 8 SHIFT cycles, `Done` 11 cycles after CLR entry.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the add-shift multiplier control.
//   mult_state_e : controller states (IDLE, CLR, ADD, SHIFT, HOLD)
//   MULT_BITS    : default multiplier width / iteration count
//   FN_ADD/FN_SUB: adder function select encodings (A+S / A-S)
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } mult_state_e;

  localparam int MULT_BITS = 8;

  localparam logic FN_ADD = 1'b0;
  localparam logic FN_SUB = 1'b1;

endpackage

// File: rtl/mult_bit_cnt.sv
// mult_bit_cnt: iteration counter for the multiplier control FSM.
// Ports:
//   clk   in  : clock, rising edge
//   rst_n in  : asynchronous active-low reset (count -> 0)
//   clr   in  : synchronous clear to 0
//   inc   in  : increment by one
//   last  out : count equals NUM_BITS-1 (final multiplier bit)
module mult_bit_cnt
  import mult_pkg::*;
#(
  parameter int NUM_BITS = MULT_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + ONE;
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl: control FSM for the 8-bit signed add-shift multiplier.
// Sequences clear, conditional add/subtract and arithmetic shift of the
// X:A:B chain; the last multiplier bit is subtracted (sign weight).
// Ports:
//   Clk, Reset_n  : clock (rising edge), async active-low reset
//   Run           : start request (level, synchronized upstream)
//   ClearA_LoadB  : load B from switches and clear X:A (IDLE only)
//   M             : current B[0] from the register unit
//   Clr_XA, Ld_B, Ld_XA, Shift_En : datapath strobes
//   Fn            : adder function (0 = A+S, 1 = A-S), valid with Ld_XA
//   Busy          : high in CLR/ADD/SHIFT
//   Done          : one-cycle pulse on entry to HOLD
// Build option MULT_CTRL_SKIP_ADD_EN: bits with M=0 spend no ADD cycle,
// giving latency 1 + NUM_BITS + popcount(B).
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int NUM_BITS = MULT_BITS
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_XA,
  output logic Ld_B,
  output logic Ld_XA,
  output logic Fn,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  mult_state_e state;
  logic        done_seen;  // set while in HOLD after its first cycle
  logic        last;
  logic        cnt_clr;
  logic        cnt_inc;

  mult_bit_cnt #(.NUM_BITS(NUM_BITS)) u_bit_cnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .last  (last)
  );

  // Strobe decode. The IDLE strobes are the only ones driven by a live
  // input, so they are gated with Reset_n to keep every output low while
  // reset is held.
  always_comb begin
    Clr_XA   = 1'b0;
    Ld_B     = 1'b0;
    Ld_XA    = 1'b0;
    Fn       = FN_ADD;
    Shift_En = 1'b0;
    Done     = 1'b0;
    case (state)
      IDLE: begin
        if (ClearA_LoadB && Reset_n) begin
          Ld_B   = 1'b1;
          Clr_XA = 1'b1;
        end
      end
      CLR: Clr_XA = 1'b1;
      ADD: begin
        if (M) begin
          Ld_XA = 1'b1;
          Fn    = last ? FN_SUB : FN_ADD;
        end
`ifdef MULT_CTRL_SKIP_ADD_EN
        else begin
          // The post-shift bit is only visible here, so a zero bit turns
          // this cycle into that bit's shift instead of an idle ADD.
          Shift_En = 1'b1;
        end
`endif
      end
      SHIFT: Shift_En = 1'b1;
      HOLD:  Done = !done_seen;
      default: ;
    endcase
  end

  assign Busy    = (state == CLR) || (state == ADD) || (state == SHIFT);
  assign cnt_clr = (state == CLR);
  assign cnt_inc = Shift_En && !last;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      done_seen <= 1'b0;
    end else begin
      done_seen <= (state == HOLD);
      case (state)
        IDLE: begin
          if (!ClearA_LoadB && Run) state <= CLR;
        end
        CLR: begin
`ifdef MULT_CTRL_SKIP_ADD_EN
          state <= M ? ADD : SHIFT;
`else
          state <= ADD;
`endif
        end
        ADD: begin
`ifdef MULT_CTRL_SKIP_ADD_EN
          if (!M) state <= last ? HOLD : ADD;
          else    state <= SHIFT;
`else
          state <= SHIFT;
`endif
        end
        SHIFT: state <= last ? HOLD : ADD;
        HOLD: begin
          if (!Run) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
